// File: rtl/encoder_32to5_arb_pkg.sv
// Shared constants, FSM state encoding and index helpers for the
// 32-to-5 priority encoder/arbiter.
package encoder_32to5_arb_pkg;

  localparam int N_REQ = 32;
  localparam int IDX_W = 5;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // Ascending vector: bit i of the result stands for request index i.
  function automatic logic [0:N_REQ-1] idx_onehot(input logic [0:IDX_W-1] idx);
    logic [0:N_REQ-1] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/encoder_32to5_arb_if.sv
// Request/grant bundle between a request source and encoder_32to5_arb.
interface encoder_32to5_arb_if;
  import encoder_32to5_arb_pkg::*;

  logic                en;
  logic [0:N_REQ-1]    req_in;
  logic                ack;
  logic                valid;
  logic [0:IDX_W-1]    idx;
  logic [0:N_REQ-1]    pending;
  logic                overrun;

  modport master (
    output en, req_in, ack,
    input  valid, idx, pending, overrun
  );

  modport slave (
    input  en, req_in, ack,
    output valid, idx, pending, overrun
  );

endinterface

// File: rtl/prienc_32to5.sv
// Purely combinational lowest-index-wins priority encoder; idx[0] is the MSB.
module prienc_32to5 #(
  parameter int N_REQ = 32,
  parameter int IDX_W = 5
) (
  input  logic [0:N_REQ-1] vec,
  output logic [0:IDX_W-1] idx,
  output logic             any
);

  // Scan from the highest index down so the lowest set index is written last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
      any = any | vec[i];
    end
  end

endmodule

// File: rtl/encoder_32to5_arb.sv
// Pending-request collector with a two-state grant FSM; presents the lowest
// pending index and holds it until the consumer acknowledges.
module encoder_32to5_arb
  import encoder_32to5_arb_pkg::*;
#(
  parameter int N_REQ = encoder_32to5_arb_pkg::N_REQ,
  parameter int IDX_W = encoder_32to5_arb_pkg::IDX_W
) (
  input  logic                clk,
  input  logic                reset,
  encoder_32to5_arb_if.slave  bus
);

  state_e              state_r;
  logic [0:N_REQ-1]    pending_r;
  logic                valid_r;
  logic [0:IDX_W-1]    idx_r;
  logic                overrun_r;

  logic [0:N_REQ-1]    set_s;
  logic [0:N_REQ-1]    clr_s;
  logic [0:N_REQ-1]    pending_nxt_s;
  logic                overrun_hit_s;
  logic [0:IDX_W-1]    enc_idx_s;
  logic                enc_any_s;

  prienc_32to5 #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_prienc (
    .vec (pending_r),
    .idx (enc_idx_s),
    .any (enc_any_s)
  );

  // Set/clear masks; a set landing on the bit being cleared wins and is not an overrun.
  always_comb begin
    set_s = '0;
    clr_s = '0;
    if (bus.en) begin
      set_s = bus.req_in;
    end else begin
      set_s = '0;
    end
    if (valid_r && bus.ack) begin
      clr_s = idx_onehot(idx_r);
    end else begin
      clr_s = '0;
    end
    pending_nxt_s = (pending_r & ~clr_s) | set_s;
    overrun_hit_s = |(set_s & pending_r & ~clr_s);
  end

  // Pending vector, sticky overrun and the grant FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      pending_r <= '0;
      valid_r   <= 1'b0;
      idx_r     <= '0;
      overrun_r <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      if (overrun_hit_s) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (enc_any_s) begin
            idx_r   <= enc_idx_s;
            valid_r <= 1'b1;
            state_r <= PRESENT;
          end else begin
            valid_r <= 1'b0;
          end
        end
        PRESENT: begin
          // Grant is frozen until ack; idle afterwards gives a one-cycle bubble.
          if (bus.ack) begin
            valid_r <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.valid   = valid_r;
  assign bus.idx     = idx_r;
  assign bus.pending = pending_r;
  assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_encoder_32to5_arb.sv
// Directed self-checking bench for encoder_32to5_arb; inputs change and
// outputs are sampled on the falling clock edge.
module tb_encoder_32to5_arb;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  encoder_32to5_arb_if bus ();

  encoder_32to5_arb #(
    .N_REQ (32),
    .IDX_W (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:31] bitv(input int i);
    logic [0:31] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    reset       = 1'b1;
    bus.en      = 1'b0;
    bus.req_in  = '0;
    bus.ack     = 1'b0;
    #1;
    check("rst_valid",   32'(bus.valid),   32'd0);
    check("rst_idx",     32'(bus.idx),     32'd0);
    check("rst_pending", bus.pending,      32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Single request on bit 7
    bus.en = 1'b1; bus.req_in = bitv(7);
    tick();
    bus.en = 1'b0; bus.req_in = '0;
    check("b7_pending",    bus.pending,      bitv(7));
    check("b7_valid_lat",  32'(bus.valid),   32'd0);
    tick();
    check("b7_valid",      32'(bus.valid),   32'd1);
    check("b7_idx",        32'(bus.idx),     32'd7);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("b7_ack_pend",   bus.pending,      32'd0);
    check("b7_ack_valid",  32'(bus.valid),   32'd0);
    tick();
    check("b7_idx_hold",   32'(bus.idx),     32'd7);
    check("b7_still_idle", 32'(bus.valid),   32'd0);

    // Bits 3, 12, 31 granted in index order with a bubble between grants
    bus.en = 1'b1; bus.req_in = bitv(3) | bitv(12) | bitv(31);
    tick();
    bus.en = 1'b0; bus.req_in = '0;
    check("m_pending",     bus.pending,      bitv(3) | bitv(12) | bitv(31));
    tick();
    check("m_g1_valid",    32'(bus.valid),   32'd1);
    check("m_g1_idx",      32'(bus.idx),     32'd3);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    check("m_bub1",        32'(bus.valid),   32'd0);
    check("m_pend1",       bus.pending,      bitv(12) | bitv(31));
    tick();
    check("m_g2_valid",    32'(bus.valid),   32'd1);
    check("m_g2_idx",      32'(bus.idx),     32'd12);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    check("m_bub2",        32'(bus.valid),   32'd0);
    tick();
    check("m_g3_valid",    32'(bus.valid),   32'd1);
    check("m_g3_idx",      32'(bus.idx),     32'd31);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    check("m_empty",       bus.pending,      32'd0);
    check("m_end_valid",   32'(bus.valid),   32'd0);

    // Higher-priority request while 12 is presented must not preempt it
    bus.en = 1'b1; bus.req_in = bitv(12);
    tick();
    bus.en = 1'b0; bus.req_in = '0;
    tick();
    check("p_idx12",       32'(bus.idx),     32'd12);
    bus.en = 1'b1; bus.req_in = bitv(0);
    tick();
    bus.en = 1'b0; bus.req_in = '0;
    check("p_hold_idx",    32'(bus.idx),     32'd12);
    check("p_hold_valid",  32'(bus.valid),   32'd1);
    check("p_pending",     bus.pending,      bitv(0) | bitv(12));
    // Idle ack while presenting nothing would be ignored; here ack the 12
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    check("p_bubble",      32'(bus.valid),   32'd0);
    tick();
    check("p_next_idx",    32'(bus.idx),     32'd0);
    check("p_next_valid",  32'(bus.valid),   32'd1);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    check("p_overrun0",    32'(bus.overrun), 32'd0);
    // ack with valid low must not clear anything
    bus.en = 1'b1; bus.req_in = bitv(20); bus.ack = 1'b1;
    tick();
    bus.en = 1'b0; bus.req_in = '0;
    check("ign_ack_pend",  bus.pending,      bitv(20));
    tick();
    bus.ack = 1'b0;
    check("ign_ack_valid", 32'(bus.valid),   32'd1);
    check("ign_ack_idx",   32'(bus.idx),     32'd20);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;

    // Same-cycle ack and re-request of 5: set wins, no overrun
    bus.en = 1'b1; bus.req_in = bitv(5);
    tick();
    bus.en = 1'b0; bus.req_in = '0;
    tick();
    check("s_idx5",        32'(bus.idx),     32'd5);
    bus.ack = 1'b1; bus.en = 1'b1; bus.req_in = bitv(5);
    tick();
    bus.ack = 1'b0; bus.en = 1'b0; bus.req_in = '0;
    check("s_pend_kept",   bus.pending,      bitv(5));
    check("s_overrun0",    32'(bus.overrun), 32'd0);
    check("s_bubble",      32'(bus.valid),   32'd0);
    tick();
    check("s_regrant",     32'(bus.idx),     32'd5);
    check("s_regrant_v",   32'(bus.valid),   32'd1);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    check("s_empty",       bus.pending,      32'd0);

    // Re-request of pending bit 9 raises sticky overrun
    bus.en = 1'b1; bus.req_in = bitv(9);
    tick();
    check("o_overrun0",    32'(bus.overrun), 32'd0);
    tick();
    bus.en = 1'b0; bus.req_in = '0;
    check("o_overrun1",    32'(bus.overrun), 32'd1);
    check("o_idx9",        32'(bus.idx),     32'd9);
    tick();
    check("o_sticky",      32'(bus.overrun), 32'd1);

    // Asynchronous reset between edges while presenting idx 9
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid",      32'(bus.valid),   32'd0);
    check("ar_pending",    bus.pending,      32'd0);
    check("ar_overrun",    32'(bus.overrun), 32'd0);
    check("ar_idx",        32'(bus.idx),     32'd0);
    @(negedge clk);
    bus.en = 1'b1; bus.req_in = '1; bus.ack = 1'b1;
    tick();
    check("ar_ign_req",    bus.pending,      32'd0);
    reset = 1'b0; bus.en = 1'b0; bus.ack = 1'b0;
    tick();
    check("en0_pending",   bus.pending,      32'd0);
    check("en0_valid",     32'(bus.valid),   32'd0);
    bus.req_in = '0;

    // First grant after release follows normal latency
    bus.en = 1'b1; bus.req_in = bitv(2);
    tick();
    bus.en = 1'b0; bus.req_in = '0;
    check("post_pending",  bus.pending,      bitv(2));
    check("post_valid0",   32'(bus.valid),   32'd0);
    tick();
    check("post_valid1",   32'(bus.valid),   32'd1);
    check("post_idx",      32'(bus.idx),     32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/encoder_32to5_arb.md
ENCODER_32TO5_ARB -- requirements
Module: encoder_32to5_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 32, number of request lines (fixed at 32 in this revision).
REQ-002 SHALL have parameter IDX_W, default 5, encoded index width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  when high, req_in is sampled into pending.
REQ-006 SHALL have port req_in  input  [0:31]  request lines; bit i requests index i.
REQ-007 SHALL have port ack  input  1  consumer accepts the presented index.
REQ-008 SHALL have port valid  output  1  idx holds a valid pending index.
REQ-009 SHALL have port idx  output  [0:4]  encoded index; idx[0] is MSB (index 1 = 5'b00001).
REQ-010 SHALL have port pending  output  [0:31]  registered pending request vector.
REQ-011 SHALL have port overrun  output  1  sticky flag: request arrived on an already-pending line.

Function
REQ-012 SHALL set pending[i] on each rising edge where en=1 and req_in[i]=1.
REQ-013 SHALL clear pending[idx] on the rising edge where valid=1 and ack=1.
REQ-014 SHALL keep pending[i] set when set and clear hit the same bit in one cycle (set wins).
REQ-015 SHALL encode priority as lowest index wins (req 0 highest, req 31 lowest).
REQ-016 SHALL implement FSM states IDLE and PRESENT.
REQ-017 IDLE: if pending nonzero, SHALL register idx = lowest set index, assert valid, enter PRESENT; else stay IDLE with valid=0.
REQ-018 PRESENT: SHALL hold idx and valid stable until ack=1, regardless of new higher-priority requests.
REQ-019 PRESENT with ack=1: SHALL deassert valid on the next edge and return to IDLE (one-cycle bubble between grants).
REQ-020 SHALL ignore ack while valid=0.
REQ-021 Latency: req_in pulse sampled at edge N SHALL appear in pending after edge N, and valid SHALL assert after edge N+1 when FSM was IDLE.
REQ-022 SHALL set overrun on an edge where en=1, req_in[i]=1, pending[i]=1 and bit i is not being cleared that edge; overrun stays set until reset.
REQ-023 Sampling with en=0 SHALL leave pending unchanged except for ack clearing.
REQ-024 idx SHALL hold its last value when valid=0 (no X, no forced zero).

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, pending=0, valid=0, idx=5'b00000, overrun=0, independent of clk.
REQ-026 Reset mid-PRESENT SHALL discard the presented index without clearing-side effects; first grant after release follows REQ-021.
REQ-027 Requests or ack asserted while reset is high SHALL be ignored.

Structure
REQ-028 Shared package SHALL hold N_REQ, IDX_W and the FSM state encoding (IDLE=0, PRESENT=1).
REQ-029 Combinational lowest-index priority encode SHALL be one sub-module, prienc_32to5 (inputs [0:31] vector, outputs [0:4] index plus any flag), instantiated once.
REQ-030 All state SHALL live in encoder_32to5_arb; sub-module SHALL be purely combinational.

Verification
REQ-031 Reset then req_in=bit 7 pulse with en=1 -> pending=bit 7 next cycle, valid=1 idx=5'b00111 one cycle later; ack -> pending=0, valid=0.
REQ-032 req_in bits 3, 12, 31 together -> grants in order idx 3, 12, 31, each separated by one valid=0 cycle, pending empty after third ack.
REQ-033 While idx=12 presented (no ack), pulse req bit 0 -> idx stays 12; after ack, next grant idx=0.
REQ-034 Presenting idx=5, same cycle ack=1 and req_in bit 5 -> pending[5] stays 1, overrun stays 0, idx 5 re-granted after bubble; separate re-request of pending bit 9 -> overrun=1.
REQ-035 reset asserted asynchronously mid-PRESENT (between edges) -> valid, pending, overrun drop to 0 without a clock edge; en=0 with req_in=all ones -> pending stays 0.
